// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program/data loader.
//   - Default memory geometry (instruction word/address width, data address width)
//   - Command byte encodings that open a frame
//   - Loader state enumeration and the state a load frame finishes in
// Optional feature macro: LOADER_CSUM_EN adds a trailing checksum byte (CSUM state)
// to every IMEM/DMEM frame.
package prog_loader_pkg;

    localparam int PL_IW = 9;   // instruction word width
    localparam int PL_IA = 12;  // instruction address width
    localparam int PL_DA = 8;   // data memory address width

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        I_AH,
        I_AL,
        I_CH,
        I_CL,
        I_WH,
        I_WL,
        D_A,
        D_C,
        D_W,
`ifdef LOADER_CSUM_EN
        CSUM,
`endif
        RUN
    } state_t;

    // Where a load frame goes once its last word has been written.
`ifdef LOADER_CSUM_EN
    localparam state_t FRAME_END = CSUM;
`else
    localparam state_t FRAME_END = IDLE;
`endif

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program/data loader: the writer side of the core's instruction and
// data memories, plus the core run/done handshake.
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   in_valid/in_data   incoming command/payload byte stream
//   in_ready           byte accepted when in_valid & in_ready (low only while running)
//   imem_we/addr/wdata instruction memory write port, one-cycle strobe per word
//   dmem_we/addr/wdata data memory write port, one-cycle strobe per byte
//   core_done          core finished; returns the loader to IDLE
//   core_run           core released and executing
//   busy               a frame is in progress
//   err                sticky error (unknown command, or checksum mismatch)
//
// Frames: 01 ah al ch cl {hi lo}*N  -> N = c+1 instruction words at a, a+1, ...
//         02 a c {d}*N              -> N = c+1 data bytes at a, a+1, ...
//         03                        -> run the core until core_done
// Optional feature macro: LOADER_CSUM_EN appends one checksum byte to each
// IMEM/DMEM frame (mod-256 sum of every byte after the command byte).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IW = PL_IW,
    parameter int IA = PL_IA,
    parameter int DA = PL_DA
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [IA-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          dmem_we,
    output logic [DA-1:0] dmem_addr,
    output logic [7:0]    dmem_wdata,
    input  logic          core_done,
    output logic          core_run,
    output logic          busy,
    output logic          err
);

    state_t        state;
    logic [IA-1:0] addr;   // next write address (dmem uses the low DA bits)
    logic [IA-1:0] cnt;    // words remaining after the current one
    logic [IW-9:0] whi;    // upper instruction bits captured from the hi byte
    logic          take;

    assign take = in_valid & in_ready;
    assign busy = (state != IDLE) && (state != RUN);

`ifdef LOADER_CSUM_EN
    logic [7:0] csum;

    // Restarts on the command byte, then sums header and payload bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (take) begin
            csum <= (state == IDLE) ? 8'h00 : csum + in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: in_ready is a register rather than a decode of state, so it
            // reads 0 while reset is held and rises on the first clock after release.
            state      <= IDLE;
            in_ready   <= 1'b0;
            core_run   <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            addr       <= '0;
            cnt        <= '0;
            whi        <= '0;
        end else begin
            // NOTE: these defaults are non-blocking, so a branch below that assigns
            // the same signal simply wins; strobes therefore last exactly one cycle.
            imem_we  <= 1'b0;
            dmem_we  <= 1'b0;
            in_ready <= 1'b1;

            case (state)
                IDLE: begin
                    if (take) begin
                        case (in_data)
                            CMD_IMEM: state <= I_AH;
                            CMD_DMEM: state <= D_A;
                            CMD_RUN: begin
                                state    <= RUN;
                                core_run <= 1'b1;
                                in_ready <= 1'b0;
                            end
                            default:  err <= 1'b1;
                        endcase
                    end
                end

                I_AH: if (take) begin
                    addr[IA-1:8] <= in_data[IA-9:0];
                    state        <= I_AL;
                end
                I_AL: if (take) begin
                    addr[7:0] <= in_data;
                    state     <= I_CH;
                end
                I_CH: if (take) begin
                    cnt[IA-1:8] <= in_data[IA-9:0];
                    state       <= I_CL;
                end
                I_CL: if (take) begin
                    cnt[7:0] <= in_data;
                    state    <= I_WH;
                end
                I_WH: if (take) begin
                    whi   <= in_data[IW-9:0];
                    state <= I_WL;
                end
                I_WL: if (take) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= addr;
                    imem_wdata <= {whi, in_data};
                    addr       <= addr + IA'(1);
                    cnt        <= cnt - IA'(1);
                    state      <= (cnt == '0) ? FRAME_END : I_WH;
                end

                D_A: if (take) begin
                    addr  <= IA'(in_data);
                    state <= D_C;
                end
                D_C: if (take) begin
                    cnt   <= IA'(in_data);
                    state <= D_W;
                end
                D_W: if (take) begin
                    dmem_we    <= 1'b1;
                    dmem_addr  <= addr[DA-1:0];
                    dmem_wdata <= in_data;
                    // Carry out of the low DA bits is never observed, giving the wrap.
                    addr       <= addr + IA'(1);
                    cnt        <= cnt - IA'(1);
                    state      <= (cnt == '0) ? FRAME_END : D_W;
                end

`ifdef LOADER_CSUM_EN
                CSUM: if (take) begin
                    if (in_data != csum) err <= 1'b1;
                    state <= IDLE;
                end
`endif

                RUN: begin
                    if (core_done) begin
                        core_run <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Frames are described at the transaction
// level (base address, list of words); the expected memory writes are derived
// from them with modulo arithmetic and compared against writes observed on the
// strobes. Honours LOADER_CSUM_EN the same way the design does.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        core_done = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [8:0]  imem_wdata;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        core_run;
    logic        busy;
    logic        err;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .core_done  (core_done),
        .core_run   (core_run),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // {is_imem, address, data}
    typedef struct packed {
        logic        mem;
        logic [11:0] addr;
        logic [8:0]  data;
    } wr_t;

    typedef struct {
        logic [55:0] bytes;  // frame bytes, left aligned
        int          nb;
        logic        mem;
        logic [11:0] addr;
        logic [8:0]  data;
    } vec_t;

    wr_t  obs[$];
    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = -10;
    logic exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Every strobe must land in the cycle right after the byte that completed it.
    always @(negedge clk) begin
        if (imem_we) begin
            obs.push_back({1'b1, imem_addr, imem_wdata});
            check("imem_we_latency", 32'(cyc), 32'(acc_cyc));
        end
        if (dmem_we) begin
            obs.push_back({1'b0, 4'h0, dmem_addr, 1'b0, dmem_wdata});
            check("dmem_we_latency", 32'(cyc), 32'(acc_cyc));
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Sends a load frame with random idle gaps; appends the checksum when enabled.
    task automatic send_frame(input logic [7:0] q[$], input bit bad_csum);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(q[i]);
            if (i > 0) sum = sum + q[i];
        end
`ifdef LOADER_CSUM_EN
        if (bad_csum) begin
            sum     = sum + 8'h01;
            exp_err = 1'b1;
        end
        send_byte(sum);
`else
        if (bad_csum) sum = 8'h00;
`endif
    endtask

    task automatic compare_writes(input string name);
        repeat (2) @(negedge clk);
        check({name, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check({name, "_write"}, 32'(obs[i]), 32'(exp_q[i]));
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_busy"}, 32'(busy), 32'd0);
        obs.delete();
        exp_q.delete();
    endtask

    task automatic run_imem(input string name, input int base, input logic [8:0] words[$],
                            input bit junk, input bit bad_csum);
        logic [7:0]  q[$];
        logic [11:0] n1;
        n1 = 12'(words.size() - 1);
        q.push_back(8'h01);
        q.push_back({4'h0, 4'(base >> 8)});
        q.push_back(8'(base));
        q.push_back({4'h0, n1[11:8]});
        q.push_back(n1[7:0]);
        foreach (words[i]) begin
            q.push_back({junk ? 7'($urandom) : 7'h00, words[i][8]});
            q.push_back(words[i][7:0]);
            exp_q.push_back({1'b1, 12'((base + i) % 4096), words[i]});
        end
        send_frame(q, bad_csum);
        compare_writes(name);
    endtask

    task automatic run_dmem(input string name, input int base, input logic [7:0] data[$],
                            input bit bad_csum);
        logic [7:0] q[$];
        q.push_back(8'h02);
        q.push_back(8'(base));
        q.push_back(8'(data.size() - 1));
        foreach (data[i]) begin
            q.push_back(data[i]);
            exp_q.push_back({1'b0, 12'((base + i) % 256), 1'b0, data[i]});
        end
        send_frame(q, bad_csum);
        compare_writes(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_core_run"}, 32'(core_run), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_we"}, {30'd0, imem_we, dmem_we}, 32'd0);
        check({name, "_addr"}, {12'd0, imem_addr, dmem_addr}, 32'd0);
        check({name, "_wdata"}, {15'd0, imem_wdata, dmem_wdata}, 32'd0);
    endtask

    initial begin
        vec_t       vt[5];
        logic [8:0] w[$];
        logic [7:0] d[$];
        logic [7:0] q[$];

        vt[0] = '{56'h010FFF000001AB, 7, 1'b1, 12'hFFF, 9'h1AB};
        vt[1] = '{56'h010ABC0000FE34, 7, 1'b1, 12'hABC, 9'h034};
        vt[2] = '{56'h01000100000100, 7, 1'b1, 12'h001, 9'h100};
        vt[3] = '{56'h0200007E000000, 4, 1'b0, 12'h000, 9'h07E};
        vt[4] = '{56'h02FF0001000000, 4, 1'b0, 12'h0FF, 9'h001};

        // Reset state while reset is held, then in_ready rises after release.
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Table of single-word frames.
        for (int v = 0; v < 5; v++) begin
            q.delete();
            for (int i = 0; i < vt[v].nb; i++) q.push_back(vt[v].bytes[55 - 8 * i -: 8]);
            exp_q.push_back({vt[v].mem, vt[v].addr, vt[v].data});
            send_frame(q, 1'b0);
            compare_writes($sformatf("vec%0d", v));
        end

        // 01 00 10 00 01 01 23 00 45
        w = '{9'h123, 9'h045};
        run_imem("imem_load", 12'h010, w, 1'b0, 1'b0);

        // 02 FE 02 AA BB CC: address wraps past 0xFF
        d = '{8'hAA, 8'hBB, 8'hCC};
        run_dmem("dmem_wrap", 8'hFE, d, 1'b0);

        // Run/done handshake; bytes offered while running are not consumed.
        send_byte(8'h03);
        check("run_core_run", 32'(core_run), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h02;
        repeat (4) @(negedge clk);
        check("run_no_write", 32'(obs.size()), 32'd0);
        check("run_held", 32'(core_run), 32'd1);
        in_valid  = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("done_core_run", 32'(core_run), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
        core_done = 1'b1;
        repeat (2) @(negedge clk);
        core_done = 1'b0;
        check("idle_done_ignored", 32'(core_run), 32'd0);
        d = '{8'h99};
        run_dmem("after_run", 8'h40, d, 1'b0);

        // Unknown command sets err and writes nothing; later frames still work.
        send_byte(8'h7F);
        exp_err = 1'b1;
        compare_writes("bad_cmd");
        d = '{8'h11};
        run_dmem("after_bad_cmd", 8'h05, d, 1'b0);

`ifdef LOADER_CSUM_EN
        d = '{8'h20};
        reset = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        run_dmem("csum_good", 8'h10, d, 1'b0);
        run_dmem("csum_bad", 8'h10, d, 1'b1);
`endif

        // Random frames against the transaction-level model.
        for (int f = 0; f < 30; f++) begin
            int kind;
            int base;
            int n;
            bit bad;
            kind = $urandom_range(0, 4);
            n    = $urandom_range(1, 5);
            bad  = ($urandom_range(0, 3) == 0);
            w.delete();
            d.delete();
            if (kind == 0) begin
                send_byte(8'($urandom_range(4, 255)));
                exp_err = 1'b1;
                compare_writes("rand_bad_cmd");
            end else if (kind <= 2) begin
                base = $urandom_range(0, 1) ? 4095 - $urandom_range(0, 3) : $urandom_range(0, 4095);
                for (int i = 0; i < n; i++) w.push_back(9'($urandom));
                run_imem("rand_imem", base, w, 1'b1, bad);
            end else begin
                base = $urandom_range(0, 1) ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255);
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
                run_dmem("rand_dmem", base, d, bad);
            end
        end

        // Reset in the middle of an IMEM header aborts the frame and clears err.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("midframe_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        @(negedge clk);
        reset   = 1'b1;
        exp_err = 1'b0;
        obs.delete();
        d = '{8'h55};
        run_dmem("after_reset", 8'h00, d, 1'b0);

        // core_run falls as soon as reset asserts, without a clock edge.
        send_byte(8'h03);
        check("run_before_reset", 32'(core_run), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("run_async_drop", 32'(core_run), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("run_reset_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program/data loader. It is the writer side of the core's instruction memory (9-bit words, 12-bit address) and data memory (8-bit words, 8-bit address).
- Parses command frames from a valid/ready byte stream and issues single-cycle write strobes into both memories.
- Gates the core through core_run, and returns to loading when the core signals done.

Parameters:
- IW, 9, instruction word width
- IA, 12, instruction address width
- DA, 8, data memory address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
- imem_we  out  1  instruction write strobe, 1-cycle pulse
- imem_addr  out  IA  instruction write address
- imem_wdata  out  IW  instruction write word
- dmem_we  out  1  data write strobe, 1-cycle pulse
- dmem_addr  out  DA  data write address
- dmem_wdata  out  8  data write byte
- core_done  in  1  core's done flag
- core_run  out  1  1 = core released from reset and executing
- busy  out  1  mid-frame (state != IDLE and != RUN)
- err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state=IDLE, every output 0 except in_ready=1 after the reset edge releases.
- Commands (first byte of a frame):
  - CMD_IMEM=0x01: then addr_hi[3:0], addr_lo, cnt_hi[3:0], cnt_lo. Word count N = cnt+1 (1..4096). Then N words, 2 bytes each: hi byte bit0 = wdata[8] (bits 7:1 ignored), then lo byte = wdata[7:0].
  - CMD_DMEM=0x02: then addr, cnt. N = cnt+1 (1..256). Then N data bytes.
  - CMD_RUN=0x03: core_run←1, state→RUN.
  - Any other command byte: err←1, stay IDLE, byte consumed.
- States: IDLE, I_AH, I_AL, I_CH, I_CL, I_WH, I_WL, D_A, D_C, D_W, [CSUM], RUN. Each accepted byte advances exactly one state.
- Write latency: strobe asserts the cycle after the final byte of a word is accepted (I_WL or D_W byte), with address/data registered in that same cycle. Addresses are stable while the strobe is high.
- Address increments after each write and wraps modulo 2^IA / 2^DA (imem 0xFFF→0x000, dmem 0xFF→0x00).
- Word counter decrements per write. After the last word, go to IDLE (or CSUM when enabled).
- in_ready=1 in all states except RUN. No back-pressure is ever applied mid-frame; the source may idle (in_valid=0) indefinitely between bytes.
- In RUN: in_ready=0, no writes. When core_done=1 is sampled: core_run←0, state→IDLE on the next edge.
- core_done ignored outside RUN.
- err clears only on reset. Frames are still processed after err is set.
- Reset mid-frame aborts the frame. Words already written stay written. core_run drops immediately (async).

Optional Feature:
- Macro LOADER_CSUM_EN.
- When defined: every IMEM/DMEM frame ends with one checksum byte, equal to the 8-bit modulo-256 sum of all bytes after the command byte (header and payload). On mismatch: err←1. Writes are not rolled back. Then IDLE.
- When undefined: no checksum byte, no CSUM state, and the frame ends at the last word.

Decomposition:
- Package prog_loader_pkg: command constants CMD_IMEM/CMD_DMEM/CMD_RUN, state enum typedef, IW/IA/DA defaults.
- Single module; no sub-module needed. The checksum accumulator stays inline under the macro.

Test Plan:
- IMEM load: 01 00 10 00 01 01 23 00 45 → writes imem[0x010]=0x123, then imem[0x011]=0x045. Each imem_we pulse is 1 cycle, 1 cycle after the lo byte. Then busy=0.
- DMEM wrap: 02 FE 02 AA BB CC → dmem[0xFE]=AA, dmem[0xFF]=BB, dmem[0x00]=CC.
- Run/done: 03 → core_run=1 and in_ready=0. In this state, bytes presented with in_valid=1 are not consumed. core_done pulse → core_run=0, in_ready=1 next cycle.
- Bad command 0x7F → err=1, no writes. The following 02 05 00 11 still writes dmem[0x05]=0x11.
- Reset asserted after 01 00 00 00 → outputs 0 immediately. After release, 02 00 00 55 writes dmem[0]=0x55 normally.
- LOADER_CSUM_EN: 02 10 00 20 30 → no err (0x10+0x00+0x20=0x30). The same frame with checksum 0x31 → err=1, but dmem[0x10]=0x20 is still written.
